// File: rtl/usb_pck_pkg.sv
// usb_pck_coder shared types: FSM states, CRC8-ATM constants and the
// byte-wise CRC update used by the CRC register.
package usb_pck_pkg;

   typedef enum logic [3:0] {
      S_IDLE, S_CTRL, S_PHH, S_PHL, S_ADDR,
      S_NUMH, S_NUML, S_CRCH, S_DATA, S_CRCD
   } state_t;

   localparam logic [7:0] CRC8_ATM_POLY = 8'h07;
   localparam int         HDR_BYTES     = 6;

   function automatic logic [7:0] usb_crc8_atm_next(
      input logic [7:0] crc,
      input logic [7:0] b
   );
      logic [7:0] c;
      c = crc ^ b;
      for (int i = 0; i < 8; i++)
         c = c[7] ? ((c << 1) ^ CRC8_ATM_POLY) : (c << 1);
      return c;
   endfunction

endpackage

// File: rtl/usb_pck_coder_if.sv
// Request, payload and output streams of usb_pck_coder.
// master = packet source/sink side, slave = the coder.
interface usb_pck_coder_if
   import usb_pck_pkg::*;
#(
   parameter int LEN_W = 16
) ();

   logic             req_valid;
   logic             req_ready;
   logic [7:0]       req_ctrl;
   logic [15:0]      req_ph;
   logic [7:0]       req_addr;
   logic [LEN_W-1:0] req_num;
   logic [7:0]       d;
   logic             d_valid;
   logic             d_ready;
   logic [7:0]       q;
   logic             q_valid;
   logic             q_ready;
   logic             busy;
   logic             pck_sent;
   logic             err_len;

   modport master (
      output req_valid, req_ctrl, req_ph, req_addr, req_num,
      output d, d_valid, q_ready,
      input  req_ready, d_ready, q, q_valid,
      input  busy, pck_sent, err_len
   );

   modport slave (
      input  req_valid, req_ctrl, req_ph, req_addr, req_num,
      input  d, d_valid, q_ready,
      output req_ready, d_ready, q, q_valid,
      output busy, pck_sent, err_len
   );

endinterface

// File: rtl/usb_crc8_atm.sv
// Byte-wide CRC8-ATM register; load has priority over en.
module usb_crc8_atm
   import usb_pck_pkg::*;
(
   input  logic       clk,
   input  logic       n_rst,
   input  logic       load,
   input  logic [7:0] init,
   input  logic       en,
   input  logic [7:0] d,
   output logic [7:0] crc
);

   logic [7:0] r_crc;

   always_ff @(posedge clk) begin
      if (!n_rst)
         r_crc <= 8'h00;
      else if (load)
         r_crc <= init;
      else if (en)
         r_crc <= usb_crc8_atm_next(r_crc, d);
   end

   assign crc = r_crc;

endmodule

// File: rtl/usb_pck_coder.sv
// USB packet framer: header, header CRC8-ATM, payload, payload CRC8-ATM.
// Define USB_PCK_CODER_ZLP_EN to accept zero-length payloads.
module usb_pck_coder
   import usb_pck_pkg::*;
#(
   parameter int         LEN_W    = 16,
   parameter int         MAX_LEN  = 1024,
   parameter logic [7:0] CRC_INIT = 8'h00
) (
   input  logic           clk,
   input  logic           n_rst,
   usb_pck_coder_if.slave bus
);

   state_t           r_state;
   state_t           w_next;
   logic [7:0]       r_ctrl;
   logic [15:0]      r_ph;
   logic [7:0]       r_addr;
   logic [LEN_W-1:0] r_num;
   logic [LEN_W-1:0] r_cnt;
   logic             r_pck_sent;
   logic             r_err_len;

   logic [7:0]  w_hdr [HDR_BYTES];
   logic [2:0]  w_hidx;
   logic [15:0] w_num16;
   logic        w_bad_len;
   logic        w_zero_bad;
   logic        w_accept;
   logic        w_req_ready;
   logic [7:0]  w_q;
   logic        w_q_valid;
   logic        w_d_ready;
   logic        w_crc_load;
   logic        w_crc_en;
   logic [7:0]  w_crc_d;
   logic [7:0]  w_crc;
   logic        w_dec;
   logic        w_pck_set;
   logic        w_err_set;

   assign w_num16  = 16'(r_num);
   assign w_hdr[0] = r_ctrl;
   assign w_hdr[1] = r_ph[15:8];
   assign w_hdr[2] = r_ph[7:0];
   assign w_hdr[3] = r_addr;
   assign w_hdr[4] = w_num16[15:8];
   assign w_hdr[5] = w_num16[7:0];
   assign w_hidx   = 3'(r_state - S_CTRL);

`ifdef USB_PCK_CODER_ZLP_EN
   assign w_zero_bad = 1'b0;
`else
   assign w_zero_bad = (bus.req_num == '0);
`endif

   assign w_bad_len = (32'(bus.req_num) > 32'(MAX_LEN)) | w_zero_bad;

   // Reset forces every output to its idle value, whatever the state.
   always_comb begin
      w_next      = r_state;
      w_req_ready = 1'b0;
      w_accept    = 1'b0;
      w_q         = 8'h00;
      w_q_valid   = 1'b0;
      w_d_ready   = 1'b0;
      w_crc_load  = 1'b0;
      w_crc_en    = 1'b0;
      w_crc_d     = 8'h00;
      w_dec       = 1'b0;
      w_pck_set   = 1'b0;
      w_err_set   = 1'b0;
      if (n_rst) begin
         unique case (r_state)
            S_IDLE: begin
               w_req_ready = 1'b1;
               if (bus.req_valid) begin
                  w_accept   = 1'b1;
                  w_crc_load = 1'b1;
                  if (w_bad_len)
                     w_err_set = 1'b1;
                  else
                     w_next = S_CTRL;
               end
            end
            S_CTRL, S_PHH, S_PHL,
            S_ADDR, S_NUMH, S_NUML: begin
               w_q       = w_hdr[w_hidx];
               w_q_valid = 1'b1;
               w_crc_d   = w_q;
               w_crc_en  = bus.q_ready;
               if (bus.q_ready)
                  w_next = state_t'(r_state + 4'd1);
            end
            S_CRCH: begin
               w_q       = w_crc;
               w_q_valid = 1'b1;
               if (bus.q_ready) begin
                  w_crc_load = 1'b1;
                  w_next     = S_DATA;
`ifdef USB_PCK_CODER_ZLP_EN
                  if (r_cnt == '0) begin
                     w_next    = S_IDLE;
                     w_pck_set = 1'b1;
                  end
`endif
               end
            end
            S_DATA: begin
               w_q       = bus.d;
               w_q_valid = bus.d_valid;
               w_d_ready = bus.q_ready;
               if (bus.d_valid && bus.q_ready) begin
                  w_crc_d  = bus.d;
                  w_crc_en = 1'b1;
                  w_dec    = 1'b1;
                  if (r_cnt == LEN_W'(1))
                     w_next = S_CRCD;
               end
            end
            S_CRCD: begin
               w_q       = w_crc;
               w_q_valid = 1'b1;
               if (bus.q_ready) begin
                  w_next    = S_IDLE;
                  w_pck_set = 1'b1;
               end
            end
            default: w_next = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!n_rst) begin
         r_state    <= S_IDLE;
         r_ctrl     <= 8'h00;
         r_ph       <= 16'h0000;
         r_addr     <= 8'h00;
         r_num      <= '0;
         r_cnt      <= '0;
         r_pck_sent <= 1'b0;
         r_err_len  <= 1'b0;
      end else begin
         r_state    <= w_next;
         r_pck_sent <= w_pck_set;
         r_err_len  <= w_err_set;
         if (w_accept) begin
            r_ctrl <= bus.req_ctrl;
            r_ph   <= bus.req_ph;
            r_addr <= bus.req_addr;
            r_num  <= bus.req_num;
            r_cnt  <= bus.req_num;
         end else if (w_dec) begin
            r_cnt  <= r_cnt - LEN_W'(1);
         end
      end
   end

   usb_crc8_atm u_crc (
      .clk   (clk),
      .n_rst (n_rst),
      .load  (w_crc_load),
      .init  (CRC_INIT),
      .en    (w_crc_en),
      .d     (w_crc_d),
      .crc   (w_crc)
   );

   assign bus.req_ready = w_req_ready;
   assign bus.q         = w_q;
   assign bus.q_valid   = w_q_valid;
   assign bus.d_ready   = w_d_ready;
   assign bus.busy      = n_rst & (r_state != S_IDLE);
   assign bus.pck_sent  = r_pck_sent;
   assign bus.err_len   = r_err_len;

endmodule

// File: tb/tb_usb_pck_coder.sv
// Self-checking bench for usb_pck_coder: scoreboard of expected bytes
// filled on request acceptance, compared on every output transfer.
`timescale 1ns/1ps
module tb_usb_pck_coder;
   import usb_pck_pkg::*;

   localparam int LEN_W   = 16;
   localparam int MAX_LEN = 1024;

   typedef struct {
      logic [7:0] b;
      bit         first;
      bit         last;
      int         pk;
   } exp_t;

   logic clk = 1'b0;
   logic n_rst;
   int   n_vec = 0;
   int   n_err = 0;

   exp_t       sb [$];
   logic [7:0] pc  [4];
   logic [15:0] pph [4];
   logic [7:0] pa  [4];
   int         pn  [4];
   logic [7:0] pb  [4];
   int         first_cyc [4];
   int         last_cyc  [4];
   int         qv_cycles;
   int         pck_cnt;
   logic [7:0] last_byte;

   usb_pck_coder_if #(.LEN_W(LEN_W)) bus ();

   usb_pck_coder #(
      .LEN_W    (LEN_W),
      .MAX_LEN  (MAX_LEN),
      .CRC_INIT (8'h00)
   ) dut (
      .clk   (clk),
      .n_rst (n_rst),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Bit-serial reference CRC8-ATM, MSB first.
   function automatic logic [7:0] ref_crc(input logic [7:0] c,
                                          input logic [7:0] b);
      logic fb;
      for (int i = 7; i >= 0; i--) begin
         fb = c[7] ^ b[i];
         c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
      end
      return c;
   endfunction

   task automatic push_pkt(input int k);
      logic [7:0]  h [6];
      logic [7:0]  c;
      logic [15:0] n16;
      exp_t        e;
      n16 = 16'(pn[k]);
      h[0] = pc[k];
      h[1] = pph[k][15:8];
      h[2] = pph[k][7:0];
      h[3] = pa[k];
      h[4] = n16[15:8];
      h[5] = n16[7:0];
      c = 8'h00;
      e.pk = k;
      e.last = 1'b0;
      for (int i = 0; i < 6; i++) begin
         c = ref_crc(c, h[i]);
         e.b = h[i];
         e.first = (i == 0);
         sb.push_back(e);
      end
      e.first = 1'b0;
      e.b = c;
      e.last = (pn[k] == 0);
      sb.push_back(e);
      c = 8'h00;
      for (int i = 0; i < pn[k]; i++) begin
         e.b = pb[k] + 8'(i);
         c = ref_crc(c, e.b);
         sb.push_back(e);
      end
      if (pn[k] > 0) begin
         e.b = c;
         e.last = 1'b1;
         sb.push_back(e);
      end
   endtask

   task automatic set_pkt(input int k, input logic [7:0] c,
                          input logic [15:0] ph, input logic [7:0] a,
                          input int n, input logic [7:0] base);
      pc[k] = c; pph[k] = ph; pa[k] = a; pn[k] = n; pb[k] = base;
   endtask

   // Drives npk requests back to back with optional random stalls;
   // abort_at >= 0 pulses n_rst once that many payload bytes moved.
   task automatic run(input int npk, input bit stall, input int abort_at);
      int   pk, dpk, idx, cyc, pend_pck;
      bit   hold, dv, done;
      logic [7:0] hq;
      exp_t e;
      pk = 0; dpk = 0; idx = 0; cyc = 0; pend_pck = -1;
      hold = 1'b0; dv = 1'b0; done = 1'b0; hq = 8'h00;
      pck_cnt = 0; qv_cycles = 0;
      for (int k = 0; k < 4; k++) begin
         first_cyc[k] = -1;
         last_cyc[k]  = -1;
      end
      while (dpk < npk && pn[dpk] == 0) dpk++;
      @(posedge clk); #1;
      while (!done) begin
         bus.req_valid = (pk < npk);
         if (pk < npk) begin
            bus.req_ctrl = pc[pk];
            bus.req_ph   = pph[pk];
            bus.req_addr = pa[pk];
            bus.req_num  = LEN_W'(pn[pk]);
         end
         if (dpk < npk) begin
            if (!dv) dv = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
            bus.d = pb[dpk] + 8'(idx);
         end else begin
            dv = 1'b0;
            bus.d = 8'h00;
         end
         bus.d_valid = dv;
         bus.q_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
         if (abort_at >= 0 && dpk == 0 && idx == abort_at) begin
            n_rst = 1'b0;
            bus.req_valid = 1'b0;
            bus.d_valid = 1'b0;
            @(negedge clk);
            n_vec++;
            if (bus.req_ready !== 1'b0 || bus.q_valid !== 1'b0) begin
               n_err++;
               $display("FAIL abort_in_reset: rdy=%b qv=%b want 0 0",
                        bus.req_ready, bus.q_valid);
            end
            @(posedge clk); #1;
            n_rst = 1'b1;
            sb.delete();
            @(negedge clk);
            n_vec++;
            if (bus.busy !== 1'b0 || bus.req_ready !== 1'b1 ||
                bus.q_valid !== 1'b0 || bus.q !== 8'h00 ||
                bus.d_ready !== 1'b0 || bus.pck_sent !== 1'b0 ||
                bus.err_len !== 1'b0) begin
               n_err++;
               $display("FAIL abort_idle: busy=%b rdy=%b qv=%b q=%h dr=%b ps=%b el=%b want 0 1 0 00 0 0 0",
                        bus.busy, bus.req_ready, bus.q_valid, bus.q,
                        bus.d_ready, bus.pck_sent, bus.err_len);
            end
            @(posedge clk); #1;
            done = 1'b1;
            continue;
         end
         @(negedge clk);
         if (hold) begin
            n_vec++;
            if (bus.q_valid !== 1'b1 || bus.q !== hq) begin
               n_err++;
               $display("FAIL q_stable: qv=%b q=%h want 1 %h",
                        bus.q_valid, bus.q, hq);
            end
         end
         if (bus.q_valid === 1'b1) qv_cycles++;
         if (bus.q_valid === 1'b1 && sb.size() > 0 && sb[0].first &&
             first_cyc[sb[0].pk] < 0)
            first_cyc[sb[0].pk] = cyc;
         n_vec++;
         if (bus.pck_sent !== (cyc == pend_pck)) begin
            n_err++;
            $display("FAIL pck_sent: cyc=%0d got %b want %b",
                     cyc, bus.pck_sent, (cyc == pend_pck));
         end
         if (bus.pck_sent === 1'b1) pck_cnt++;
         if (bus.req_valid && bus.req_ready === 1'b1) begin
            push_pkt(pk);
            pk++;
         end
         if (bus.q_valid === 1'b1 && bus.q_ready) begin
            n_vec++;
            if (sb.size() == 0) begin
               n_err++;
               $display("FAIL extra_byte: got %h want none", bus.q);
            end else begin
               e = sb.pop_front();
               if (bus.q !== e.b) begin
                  n_err++;
                  $display("FAIL q_byte: pkt=%0d got %h want %h",
                           e.pk, bus.q, e.b);
               end
               if (e.last) begin
                  last_cyc[e.pk] = cyc;
                  pend_pck = cyc + 1;
               end
            end
            last_byte = bus.q;
         end
         if (bus.d_valid && bus.d_ready === 1'b1) begin
            idx++;
            dv = 1'b0;
            if (idx == pn[dpk]) begin
               dpk++;
               idx = 0;
               while (dpk < npk && pn[dpk] == 0) dpk++;
            end
         end
         hold = (bus.q_valid === 1'b1) && !bus.q_ready;
         hq = bus.q;
         @(posedge clk); #1;
         cyc++;
         if (pk == npk && sb.size() == 0 && cyc > pend_pck) done = 1'b1;
         if (cyc > 3000) begin
            n_vec++;
            n_err++;
            $display("FAIL timeout: left=%0d want 0", sb.size());
            done = 1'b1;
         end
      end
      bus.req_valid = 1'b0;
      bus.d_valid   = 1'b0;
      bus.q_ready   = 1'b0;
   endtask

   task automatic test_reset;
      n_rst = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      n_vec++;
      if (bus.req_ready !== 1'b0 || bus.q !== 8'h00 ||
          bus.q_valid !== 1'b0 || bus.d_ready !== 1'b0 ||
          bus.busy !== 1'b0 || bus.pck_sent !== 1'b0 ||
          bus.err_len !== 1'b0) begin
         n_err++;
         $display("FAIL reset_out: rdy=%b q=%h qv=%b dr=%b busy=%b ps=%b el=%b want 0 00 0 0 0 0 0",
                  bus.req_ready, bus.q, bus.q_valid, bus.d_ready,
                  bus.busy, bus.pck_sent, bus.err_len);
      end
      @(posedge clk); #1;
      n_rst = 1'b1;
      @(negedge clk);
      n_vec++;
      if (bus.req_ready !== 1'b1 || bus.busy !== 1'b0) begin
         n_err++;
         $display("FAIL idle_out: rdy=%b busy=%b want 1 0",
                  bus.req_ready, bus.busy);
      end
   endtask

   task automatic test_stall_free;
      set_pkt(0, 8'hA5, 16'h1234, 8'h07, 9, 8'h31);
      run(1, 1'b0, -1);
      n_vec++;
      if (qv_cycles !== 17 || pck_cnt !== 1 || last_byte !== 8'hF4) begin
         n_err++;
         $display("FAIL stall_free: cyc=%0d pck=%0d crc=%h want 17 1 f4",
                  qv_cycles, pck_cnt, last_byte);
      end
      n_vec++;
      if (first_cyc[0] !== 1) begin
         n_err++;
         $display("FAIL ctrl_latency: got %0d want 1", first_cyc[0]);
      end
   endtask

   task automatic test_stalls;
      set_pkt(0, 8'hA5, 16'h1234, 8'h07, 9, 8'h31);
      run(1, 1'b1, -1);
      n_vec++;
      if (pck_cnt !== 1) begin
         n_err++;
         $display("FAIL stall_pck: got %0d want 1", pck_cnt);
      end
      set_pkt(0, 8'h3C, 16'hBEEF, 8'hFF, 20, 8'hF0);
      run(1, 1'b1, -1);
      n_vec++;
      if (pck_cnt !== 1) begin
         n_err++;
         $display("FAIL stall_pck2: got %0d want 1", pck_cnt);
      end
   endtask

   task automatic test_reject(input int num, input string nm);
      @(posedge clk); #1;
      bus.req_valid = 1'b1;
      bus.req_ctrl  = 8'h11;
      bus.req_ph    = 16'h2233;
      bus.req_addr  = 8'h44;
      bus.req_num   = LEN_W'(num);
      @(negedge clk);
      n_vec++;
      if (bus.req_ready !== 1'b1) begin
         n_err++;
         $display("FAIL %s_accept: got %b want 1", nm, bus.req_ready);
      end
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      @(negedge clk);
      n_vec++;
      if (bus.err_len !== 1'b1 || bus.busy !== 1'b0 ||
          bus.q_valid !== 1'b0) begin
         n_err++;
         $display("FAIL %s_pulse: el=%b busy=%b qv=%b want 1 0 0",
                  nm, bus.err_len, bus.busy, bus.q_valid);
      end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n_vec++;
         if (bus.err_len !== 1'b0 || bus.busy !== 1'b0 ||
             bus.q_valid !== 1'b0) begin
            n_err++;
            $display("FAIL %s_after: el=%b busy=%b qv=%b want 0 0 0",
                     nm, bus.err_len, bus.busy, bus.q_valid);
         end
      end
   endtask

   task automatic test_zero_len;
`ifdef USB_PCK_CODER_ZLP_EN
      set_pkt(0, 8'h5A, 16'h0F0F, 8'h01, 0, 8'h00);
      run(1, 1'b0, -1);
      n_vec++;
      if (qv_cycles !== 7 || pck_cnt !== 1) begin
         n_err++;
         $display("FAIL zlp: bytes=%0d pck=%0d want 7 1",
                  qv_cycles, pck_cnt);
      end
`else
      test_reject(0, "zero_len");
`endif
   endtask

   task automatic test_reset_mid;
      set_pkt(0, 8'hA5, 16'h1234, 8'h07, 9, 8'h31);
      run(1, 1'b0, 4);
      set_pkt(0, 8'hC3, 16'h5678, 8'h09, 5, 8'h61);
      run(1, 1'b0, -1);
      n_vec++;
      if (pck_cnt !== 1 || qv_cycles !== 13) begin
         n_err++;
         $display("FAIL post_reset: pck=%0d cyc=%0d want 1 13",
                  pck_cnt, qv_cycles);
      end
   endtask

   task automatic test_back_to_back;
      set_pkt(0, 8'hA5, 16'h1234, 8'h07, 9, 8'h31);
      set_pkt(1, 8'h96, 16'hCAFE, 8'h22, 3, 8'h80);
      run(2, 1'b0, -1);
      n_vec++;
      if (first_cyc[1] - last_cyc[0] !== 2 || pck_cnt !== 2) begin
         n_err++;
         $display("FAIL back_to_back: gap=%0d pck=%0d want 2 2",
                  first_cyc[1] - last_cyc[0], pck_cnt);
      end
   endtask

   initial begin
      n_rst         = 1'b0;
      bus.req_valid = 1'b0;
      bus.req_ctrl  = 8'h00;
      bus.req_ph    = 16'h0000;
      bus.req_addr  = 8'h00;
      bus.req_num   = '0;
      bus.d         = 8'h00;
      bus.d_valid   = 1'b0;
      bus.q_ready   = 1'b0;
      test_reset();
      test_stall_free();
      test_stalls();
      test_reject(MAX_LEN + 1, "too_long");
      test_zero_len();
      test_reset_mid();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
